// File: rtl/golden_checker.sv
// Runs the CPU for RUN_CYCLES clocks, then compares every register with a golden memory (read latency 1, no backpressure).
// Total sequence RUN_CYCLES+NUM_REGS+1 clocks; define GCHK_SKIP_R0_EN to never count index 0 as a mismatch.
module golden_checker #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int RUN_CYCLES = 900
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] dut_addr,
  input  logic [DATA_W-1:0] dut_data,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act
);

  localparam int CNT_MAX = (RUN_CYCLES > NUM_REGS) ? RUN_CYCLES : NUM_REGS + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W:0] ERR_SAT = '1;

  typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  prev_addr;
  logic               cmp_vld;
  logic               mism;
  logic [ADDR_W:0]    err_nxt;

  assign exp_addr = dut_addr;

  // Data on the ports belongs to the index issued one cycle earlier (prev_addr).
  assign cmp_vld = (state == COMPARE) && (cnt != '0);
`ifdef GCHK_SKIP_R0_EN
  assign mism = cmp_vld && (dut_data != exp_data) && (prev_addr != '0);
`else
  assign mism = cmp_vld && (dut_data != exp_data);
`endif
  assign err_nxt = (mism && (err_count != ERR_SAT)) ? err_count + 1'b1 : err_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      prev_addr     <= '0;
      cpu_run       <= 1'b0;
      dut_addr      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            cnt           <= '0;
            cpu_run       <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            dut_addr      <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_act <= '0;
          end
        end
        RUN: begin
          if (cnt == CNT_W'(RUN_CYCLES - 1)) begin
            state    <= COMPARE;
            cnt      <= '0;
            cpu_run  <= 1'b0;
            dut_addr <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMPARE: begin
          prev_addr <= dut_addr;
          err_count <= err_nxt;
          if (mism && (err_count == '0)) begin
            first_err_idx <= prev_addr;
            first_err_exp <= exp_data;
            first_err_act <= dut_data;
          end
          if (cnt == CNT_W'(NUM_REGS)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= (err_nxt == '0);
            dut_addr <= '0;
          end else begin
            cnt      <= cnt + 1'b1;
            dut_addr <= (cnt == CNT_W'(NUM_REGS - 1)) ? '0 : dut_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_golden_checker.sv
// Randomized bench for golden_checker: a 32x32 instance and an 8x16 instance with registered memory models.
module tb_golden_checker;
  localparam int DW = 32, NR = 32, AW = 5, RC = 900;
  localparam int SDW = 16, SNR = 8, SAW = 3, SRC = 20;
`ifdef GCHK_SKIP_R0_EN
  localparam bit SKIP0 = 1'b1;
`else
  localparam bit SKIP0 = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start_s;

  logic          cpu_run, busy, done, pass;
  logic [AW-1:0] dut_addr, exp_addr, first_err_idx;
  logic [DW-1:0] dut_data, exp_data, first_err_exp, first_err_act;
  logic [AW:0]   err_count;

  logic           cpu_run_s, busy_s, done_s, pass_s;
  logic [SAW-1:0] dut_addr_s, exp_addr_s, first_err_idx_s;
  logic [SDW-1:0] dut_data_s, exp_data_s, first_err_exp_s, first_err_act_s;
  logic [SAW:0]   err_count_s;

  logic [DW-1:0]  act [NR];
  logic [DW-1:0]  expv[NR];
  logic [SDW-1:0] act_s[SNR];
  logic [SDW-1:0] exp_s[SNR];

  int total = 0;
  int bad   = 0;

  golden_checker #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .RUN_CYCLES(RC)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start), .cpu_run(cpu_run),
    .dut_addr(dut_addr), .dut_data(dut_data), .exp_addr(exp_addr), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_exp(first_err_exp), .first_err_act(first_err_act)
  );

  golden_checker #(.DATA_W(SDW), .NUM_REGS(SNR), .ADDR_W(SAW), .RUN_CYCLES(SRC)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .cpu_run(cpu_run_s),
    .dut_addr(dut_addr_s), .dut_data(dut_data_s), .exp_addr(exp_addr_s), .exp_data(exp_data_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s),
    .first_err_idx(first_err_idx_s), .first_err_exp(first_err_exp_s), .first_err_act(first_err_act_s)
  );

  // Register file debug port and golden memory: one-cycle registered reads.
  always @(posedge clk) begin
    dut_data   <= act[dut_addr];
    exp_data   <= expv[exp_addr];
    dut_data_s <= act_s[dut_addr_s];
    exp_data_s <= exp_s[exp_addr_s];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    total++;
    assert (obs === expd) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/cpu_run"}, 64'(cpu_run), 0);
    chk({tag, "/busy"}, 64'(busy), 0);
    chk({tag, "/done"}, 64'(done), 0);
    chk({tag, "/pass"}, 64'(pass), 0);
    chk({tag, "/err_count"}, 64'(err_count), 0);
    chk({tag, "/dut_addr"}, 64'(dut_addr), 0);
    chk({tag, "/exp_addr"}, 64'(exp_addr), 0);
    chk({tag, "/first_idx"}, 64'(first_err_idx), 0);
    chk({tag, "/first_exp"}, 64'(first_err_exp), 0);
    chk({tag, "/first_act"}, 64'(first_err_act), 0);
  endtask

  // Reference: scan indices in order, lowest mismatch wins, count saturates at the port maximum.
  task automatic model_big(output int ec, output int ei, output logic [63:0] ee, output logic [63:0] ea);
    ec = 0; ei = 0; ee = 0; ea = 0;
    for (int i = 0; i < NR; i++) begin
      if (expv[i] !== act[i] && !(SKIP0 && i == 0)) begin
        if (ec == 0) begin ei = i; ee = 64'(expv[i]); ea = 64'(act[i]); end
        ec++;
      end
    end
    if (ec > (1 << (AW + 1)) - 1) ec = (1 << (AW + 1)) - 1;
  endtask

  task automatic model_small(output int ec, output int ei);
    ec = 0; ei = 0;
    for (int i = 0; i < SNR; i++) begin
      if (exp_s[i] !== act_s[i] && !(SKIP0 && i == 0)) begin
        if (ec == 0) ei = i;
        ec++;
      end
    end
    if (ec > (1 << (SAW + 1)) - 1) ec = (1 << (SAW + 1)) - 1;
  endtask

  task automatic fill_random(input int n_err);
    for (int i = 0; i < NR; i++) begin
      act[i]  = $urandom;
      expv[i] = act[i];
    end
    for (int k = 0; k < n_err; k++) begin
      int j;
      j = $urandom_range(NR - 1, 0);
      act[j] = expv[j] ^ ($urandom | 32'h1);
    end
  endtask

  // One start pulse, then watch the whole sequence cycle by cycle until done.
  task automatic run_big(input string tag, input bit inject);
    int cyc, runs, seq_bad, ec, ei;
    logic [63:0] ee, ea;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; runs = 0; seq_bad = 0;
    while (!done && cyc < 3000) begin
      if (cpu_run) runs++;
      if (cyc >= RC && cyc < RC + NR) begin
        if (dut_addr !== AW'(cyc - RC)) seq_bad++;
      end else if (cyc < RC && dut_addr !== '0) seq_bad++;
      if (exp_addr !== dut_addr) seq_bad++;
      if (busy !== 1'b1) seq_bad++;
      start = inject && (cyc == 100 || cyc == RC + 10);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    model_big(ec, ei, ee, ea);
    chk({tag, "/latency"}, 64'(cyc), 64'(RC + NR + 1));
    chk({tag, "/run_cycles"}, 64'(runs), 64'(RC));
    chk({tag, "/sequence"}, 64'(seq_bad), 0);
    chk({tag, "/busy_done"}, {62'b0, busy, done}, 64'b01);
    chk({tag, "/err_count"}, 64'(err_count), 64'(ec));
    chk({tag, "/pass"}, 64'(pass), 64'(ec == 0));
    chk({tag, "/first_idx"}, 64'(first_err_idx), 64'(ei));
    chk({tag, "/first_exp"}, 64'(first_err_exp), ee);
    chk({tag, "/first_act"}, 64'(first_err_act), ea);
    repeat (3) @(negedge clk);
    chk({tag, "/hold"}, {32'(err_count), 30'b0, done, cpu_run}, {32'(ec), 30'b0, 1'b1, 1'b0});
  endtask

  initial begin
    int ec, ei, cyc;
    rst_n = 1'b0; start = 1'b0; start_s = 1'b0;
    for (int i = 0; i < NR; i++) begin act[i] = '0; expv[i] = '0; end
    for (int i = 0; i < SNR; i++) begin act_s[i] = '0; exp_s[i] = '0; end
    repeat (3) @(negedge clk);
    chk_reset("reset");
    chk("reset/small_state", {60'b0, cpu_run_s, busy_s, done_s, pass_s}, 0);
    rst_n = 1'b1;

    fill_random(0);
    run_big("match", 1'b0);

    fill_random(0);
    expv[7] = 32'h0000000A; act[7] = 32'h0000000B;
    act[20] = expv[20] ^ ($urandom | 32'h1);
    run_big("two_err", 1'b0);
    chk("two_err/idx7", {32'(first_err_idx), first_err_exp, first_err_act} != 0 ? 64'(first_err_idx) : 64'hF, 7);

    // Reset in the middle of a run discards everything.
    fill_random(4);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (400) @(negedge clk);
    chk("mid_rst/running", {62'b0, cpu_run, busy}, 64'b11);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset("mid_rst");
    fill_random(1);
    run_big("after_rst", 1'b0);

    fill_random(3);
    run_big("extra_start", 1'b1);

    fill_random(0);
    act[0] = expv[0] ^ 32'h8000_0001;
    run_big("r0_only", 1'b0);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) begin
        expv[i] = $urandom;
        act[i]  = ($urandom_range(3, 0) == 0) ? expv[i] ^ ($urandom | 32'h1) : expv[i];
      end
      run_big($sformatf("rand%0d", r), 1'b0);
    end

    // Narrow instance: every register differs.
    for (int i = 0; i < SNR; i++) begin
      exp_s[i] = 16'($urandom);
      act_s[i] = ~exp_s[i];
    end
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    cyc = 0;
    while (!done_s && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    model_small(ec, ei);
    chk("small/latency", 64'(cyc), 64'(SRC + SNR + 1));
    chk("small/err_count", 64'(err_count_s), 64'(ec));
    chk("small/first_idx", 64'(first_err_idx_s), 64'(ei));
    chk("small/first_exp", 64'(first_err_exp_s), 64'(exp_s[ei]));
    chk("small/first_act", 64'(first_err_act_s), 64'(act_s[ei]));
    chk("small/pass", 64'(pass_s), 64'(ec == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/golden_checker.md
GOLDEN_CHECKER -- requirements
Module: golden_checker

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, width of one register value.
REQ-002 The block SHALL expose parameter NUM_REGS, default 32, number of registers compared (indices 0..NUM_REGS-1).
REQ-003 The block SHALL expose parameter ADDR_W, default 5, register index width; ADDR_W SHALL satisfy 2^ADDR_W >= NUM_REGS.
REQ-004 The block SHALL expose parameter RUN_CYCLES, default 900, number of clocks the CPU runs before comparison.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse that starts a run-and-check sequence.
REQ-008 cpu_run  output  1  high while the CPU under test may execute; low freezes it.
REQ-009 dut_addr  output  ADDR_W  register index presented to the CPU register-file debug read port.
REQ-010 dut_data  input  DATA_W  CPU register value for the index presented on the previous cycle.
REQ-011 exp_addr  output  ADDR_W  index presented to the expected-value memory; always equal to dut_addr.
REQ-012 exp_data  input  DATA_W  expected value for the index presented on the previous cycle.
REQ-013 busy  output  1  high in RUN and COMPARE.
REQ-014 done  output  1  high in DONE.
REQ-015 pass  output  1  high in DONE when err_count is zero; low otherwise.
REQ-016 err_count  output  ADDR_W+1  number of mismatching registers, saturating at all-ones.
REQ-017 first_err_idx / first_err_exp / first_err_act  output  ADDR_W / DATA_W / DATA_W  index, expected value, actual value of the lowest-index mismatch.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, COMPARE, DONE.
REQ-019 IDLE: start=1 SHALL move to RUN on the next edge, clear the run counter, err_count and first_err_* fields.
REQ-020 RUN: cpu_run SHALL be 1; run counter increments each cycle; after exactly RUN_CYCLES cycles in RUN the FSM SHALL enter COMPARE with cpu_run=0.
REQ-021 COMPARE: dut_addr SHALL step 0,1,...,NUM_REGS-1 one index per cycle; each data pair SHALL be compared one cycle after its index is issued; COMPARE SHALL last exactly NUM_REGS+1 cycles, then go to DONE.
REQ-022 A compare SHALL use full DATA_W bit equality; any X/Z on inputs is the environment's concern, not handled.
REQ-023 On mismatch err_count SHALL increment (saturating); first_err_* SHALL be captured only when err_count was zero before the increment.
REQ-024 DONE: done=1, pass valid, results held stable; start=1 SHALL restart exactly as from IDLE (results cleared the next cycle).
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 cpu_run SHALL be 0 in IDLE, COMPARE and DONE.
REQ-027 dut_addr SHALL hold 0 outside COMPARE.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE in any state, including mid-RUN or mid-COMPARE, discarding partial results.
REQ-029 Reset values: cpu_run=0, busy=0, done=0, pass=0, err_count=0, dut_addr=0, first_err_idx=0, first_err_exp=0, first_err_act=0.

Configuration
REQ-030 With GCHK_SKIP_R0_EN defined, index 0 SHALL still be addressed but never counted as a mismatch (hard-wired-zero register excluded); without it, index 0 SHALL be compared like any other.

Verification
REQ-031 Reset, start pulse, exp==dut for all 32 regs -> cpu_run high exactly 900 cycles, done after 900+33 cycles, pass=1, err_count=0.
REQ-032 Regs 7 and 20 differ (exp 0x0000000A vs act 0x0000000B at 7) -> err_count=2, first_err_idx=7, first_err_exp=0x0000000A, first_err_act=0x0000000B, pass=0.
REQ-033 rst_n low for one cycle at RUN cycle 400, then start -> outputs at reset values, full new run of 900 cycles, results match the fresh data only.
REQ-034 Extra start pulses during RUN and at COMPARE cycle 10 -> no effect; total sequence length unchanged.
REQ-035 NUM_REGS=8, DATA_W=16, ADDR_W=3, all 8 regs mismatch -> err_count=8, no saturation, first_err_idx=0 (without GCHK_SKIP_R0_EN).
REQ-036 GCHK_SKIP_R0_EN defined, only reg 0 mismatches -> pass=1, err_count=0; with the macro undefined -> err_count=1, first_err_idx=0.
